// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizing for the cache-line <-> memory-burst adaptor.
// The line is moved as BEATS beats of BURST_WIDTH bits, least-significant beat first.
package cacheline_adaptor_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int BEAT_IDX_W  = $clog2(BEATS);

  // Clears the byte offset inside a line so bursts start on a line boundary.
  localparam logic [31:0] LINE_ADDR_MASK = ~32'(LINE_WIDTH / 8 - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Turns 256-bit cache line read/write requests into 4-beat 64-bit memory bursts
// and returns a one-cycle pmem_resp when the burst has completed.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pmem_read,
  input  logic                   pmem_write,
  input  logic [31:0]            pmem_address,
  input  logic [LINE_WIDTH-1:0]  pmem_wdata,
  output logic [LINE_WIDTH-1:0]  pmem_rdata,
  output logic                   pmem_resp,
  output logic                   burst_read,
  output logic                   burst_write,
  output logic [31:0]            burst_address,
  output logic [BURST_WIDTH-1:0] burst_wdata,
  input  logic [BURST_WIDTH-1:0] burst_rdata,
  input  logic                   burst_resp
);

  state_t                  state_reg, state_next;
  logic [BEAT_IDX_W-1:0]   cnt_reg, cnt_next;
  logic [31:0]             addr_reg;
  logic [BURST_WIDTH-1:0]  rbeat_reg [BEATS];
  logic [BURST_WIDTH-1:0]  wbeat_reg [BEATS];
  logic                    accept;
  logic                    in_burst;
  logic                    last_beat;

  assign accept    = (state_reg == IDLE) && (pmem_read || pmem_write);
  assign in_burst  = (state_reg == READ) || (state_reg == WRITE);
  assign last_beat = (cnt_reg == BEAT_IDX_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // A write takes priority when the cache raises both requests.
        if (pmem_write) begin
          state_next = WRITE;
        end else if (pmem_read) begin
          state_next = READ;
        end
      end
      READ, WRITE: begin
        if (burst_resp && last_beat) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    burst_read  = (state_reg == READ);
    burst_write = (state_reg == WRITE);
    pmem_resp   = (state_reg == DONE);
    burst_wdata = '0;
    if (state_reg == WRITE) begin
      burst_wdata = wbeat_reg[cnt_reg];
    end
  end

  // Cleared on the final beat so the counter never relies on wrapping.
  always_comb begin
    cnt_next = cnt_reg;
    if (accept) begin
      cnt_next = '0;
    end else if (in_burst && burst_resp) begin
      cnt_next = last_beat ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
    end else if (accept) begin
      addr_reg <= pmem_address & LINE_ADDR_MASK;
    end
  end

  assign burst_address = addr_reg;

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      always_ff @(posedge clk) begin
        if (rst) begin
          rbeat_reg[gi] <= '0;
        end else if ((state_reg == READ) && burst_resp && (cnt_reg == BEAT_IDX_W'(gi))) begin
          rbeat_reg[gi] <= burst_rdata;
        end
      end

      // The write line is captured at acceptance so later pmem_wdata changes are ignored.
      always_ff @(posedge clk) begin
        if (rst) begin
          wbeat_reg[gi] <= '0;
        end else if ((state_reg == IDLE) && pmem_write) begin
          wbeat_reg[gi] <= pmem_wdata[gi*BURST_WIDTH +: BURST_WIDTH];
        end
      end

      assign pmem_rdata[gi*BURST_WIDTH +: BURST_WIDTH] = rbeat_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: a behavioural memory responder feeds beats and checks
// write beats, while a scoreboard holds the line each cache request should complete with.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  cacheline_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_address(burst_address),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] line;      // beats memory returns (read) or line written (write)
    int           wait_mode; // 0: resp every cycle, 1: resp on alternate cycles
    logic         alter;     // scramble pmem inputs after acceptance
    logic [31:0]  exp_addr;
    int           exp_lat;
  } vec_t;

  typedef struct {
    logic         is_rd;
    logic [255:0] line;
  } sb_t;

  sb_t          sb[$];
  int           checks = 0;
  int           errors = 0;

  // Responder state shared with the sequencer.
  int           wait_mode = 0;
  logic [255:0] cur_line  = '0;
  logic [31:0]  cur_addr  = '0;
  int           mem_k     = 0;
  bit           phase     = 1'b0;
  int           rd_cycles = 0;
  int           wr_cycles = 0;
  bit           stray_req = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers beats at the negedge so the DUT samples them on the next posedge.
  always @(negedge clk) begin
    burst_resp = 1'b0;
    if (rst) begin
      mem_k = 0;
      phase = 1'b0;
    end else if (burst_read || burst_write) begin
      if (burst_read)  rd_cycles++;
      if (burst_write) wr_cycles++;
      chk("burst_address", {224'd0, burst_address}, {224'd0, cur_addr});
      if (mem_k > 3) begin
        chk("beat_overrun", 256'(mem_k), 256'd3);
      end else begin
        if (burst_write)
          chk("burst_wdata", {192'd0, burst_wdata}, {192'd0, cur_line[mem_k*64 +: 64]});
        if ((wait_mode == 0) || phase) begin
          burst_rdata = cur_line[mem_k*64 +: 64];
          burst_resp  = 1'b1;
          mem_k++;
        end
        phase = ~phase;
      end
    end else begin
      mem_k      = 0;
      phase      = 1'b0;
      burst_resp = stray_req;
    end
  end

  task automatic run_txn(input vec_t v, input int id);
    bit  seen;
    int  lat;
    sb_t e;
    @(negedge clk);
    wait_mode    = v.wait_mode;
    cur_addr     = v.exp_addr;
    cur_line     = v.line;
    rd_cycles    = 0;
    wr_cycles    = 0;
    pmem_read    = v.rd;
    pmem_write   = v.wr;
    pmem_address = v.addr;
    pmem_wdata   = v.wr ? v.line : {8{32'hCAFE_F00D}};
    sb.push_back('{is_rd: v.rd & ~v.wr, line: v.line});
    seen = 1'b0;
    lat  = 0;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(negedge clk);
      if (v.alter && cyc == 2) begin
        pmem_address = ~v.addr;
        pmem_wdata   = ~v.line;
      end
      if (pmem_resp) begin
        seen = 1'b1;
        lat  = cyc;
        e    = sb.pop_front();
        chk("resp_latency", 256'(cyc), 256'(v.exp_lat));
        if (e.is_rd) chk("pmem_rdata", pmem_rdata, e.line);
        chk("read_cycles",  256'(rd_cycles), e.is_rd ? 256'(4 * (1 + v.wait_mode)) : 256'd0);
        chk("write_cycles", 256'(wr_cycles), e.is_rd ? 256'd0 : 256'(4 * (1 + v.wait_mode)));
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    end
    if (!seen) begin
      chk("resp_timeout", 256'd0, 256'd1);
      sb.delete();
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
    end
    @(negedge clk);
    chk("resp_single_cycle", {255'd0, pmem_resp}, 256'd0);
    $display("txn %0d: rd=%0b wr=%0b addr=%h burst_addr=%h latency=%0d", id, v.rd, v.wr,
             v.addr, burst_address, lat);
  endtask

  localparam logic [255:0] LINE_RD  = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [255:0] LINE_WR  = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
  localparam logic [255:0] LINE_MIX = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                       64'h0F0F_F0F0_A5A5_5A5A, 64'hDEAD_BEEF_1357_2468};
  localparam logic [255:0] LINE_NEW = {{16{4'h8}}, {16{4'h7}}, {16{4'h6}}, {16{4'h5}}};

  vec_t vecs[5];
  vec_t v;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, LINE_RD,  0, 1'b0, 32'h0000_1220, 5};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_5678, LINE_WR,  1, 1'b0, 32'h0000_5660, 9};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0080, LINE_MIX, 0, 1'b0, 32'h0000_0080, 5};
    vecs[3] = '{1'b1, 1'b0, 32'hDEAD_BEEF, LINE_MIX, 1, 1'b1, 32'hDEAD_BEE0, 9};
    vecs[4] = '{1'b0, 1'b1, 32'h1357_9BDF, LINE_RD,  0, 1'b1, 32'h1357_9BC0, 5};

    rst          = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pmem_resp",   {255'd0, pmem_resp},     256'd0);
    chk("reset_burst_read",  {255'd0, burst_read},    256'd0);
    chk("reset_burst_write", {255'd0, burst_write},   256'd0);
    chk("reset_burst_addr",  {224'd0, burst_address}, 256'd0);
    chk("reset_burst_wdata", {192'd0, burst_wdata},   256'd0);
    chk("reset_pmem_rdata",  pmem_rdata,              256'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

    // Reset after two read beats: everything clears and the request never completes.
    @(negedge clk);
    wait_mode    = 0;
    cur_addr     = 32'h0000_0400;
    cur_line     = LINE_MIX;
    pmem_read    = 1'b1;
    pmem_address = 32'h0000_0400;
    sb.push_back('{is_rd: 1'b1, line: LINE_MIX});
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    pmem_read = 1'b0;
    @(negedge clk);
    chk("midrst_pmem_resp",   {255'd0, pmem_resp},     256'd0);
    chk("midrst_burst_read",  {255'd0, burst_read},    256'd0);
    chk("midrst_burst_write", {255'd0, burst_write},   256'd0);
    chk("midrst_burst_addr",  {224'd0, burst_address}, 256'd0);
    chk("midrst_burst_wdata", {192'd0, burst_wdata},   256'd0);
    chk("midrst_pmem_rdata",  pmem_rdata,              256'd0);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", {254'd0, pmem_resp, burst_read}, 256'd0);
    end
    $display("txn 5: read aborted by reset after 2 beats");
    v = '{1'b1, 1'b0, 32'h0000_0410, LINE_NEW, 0, 1'b0, 32'h0000_0400, 5};
    run_txn(v, 6);

    // Back-to-back read then write, with a stray beat acknowledge while idle.
    v = '{1'b1, 1'b0, 32'h0000_2000, LINE_RD, 0, 1'b0, 32'h0000_2000, 5};
    run_txn(v, 7);
    stray_req = 1'b1;
    @(negedge clk);
    #1 stray_req = 1'b0;
    @(negedge clk);
    chk("stray_idle", {253'd0, pmem_resp, burst_read, burst_write}, 256'd0);
    $display("txn 8: stray burst_resp while idle");
    v = '{1'b0, 1'b1, 32'h0000_2000, LINE_NEW, 0, 1'b0, 32'h0000_2000, 5};
    run_txn(v, 9);
    chk("rdata_held_after_write", pmem_rdata, LINE_RD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
